// File: rtl/i2c_sensor_slave.sv
// i2c_sensor_slave
//   I2C slave emulating the aquarium temperature sensor. 7-bit addressing,
//   2-bit register pointer with auto-increment (wraps 3->0), repeated START.
//   Register map:
//     0x00 temperature MSB (shadow snapshot, RO)
//     0x01 temperature LSB (shadow snapshot, RO)
//     0x02 CONFIG (RW)
//     0x03 device ID (RO)
//
// Ports
//   clk         system clock, at least 8x SCL
//   rst         synchronous reset, active-high
//   scl_i       SCL pin level (asynchronous)
//   sda_i       SDA pin level (asynchronous)
//   sda_oe      1 = pull SDA low, 0 = release (open drain)
//   temp_in     live 16-bit temperature sample
//   cfg_out     CONFIG register contents
//   cfg_wr_stb  one-clk pulse when CONFIG is written
//   busy        high from START until STOP
module i2c_sensor_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter logic [7:0] DEV_ID     = 8'hA5,
  parameter logic [7:0] CFG_RESET  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_in,
  output logic [7:0]  cfg_out,
  output logic        cfg_wr_stb,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK
  } state_t;

  // Register read mux; temperature comes from the shadow so MSB/LSB belong
  // to the same sample.
  function automatic logic [7:0] reg_rd(input logic [1:0]  p,
                                        input logic [15:0] shd,
                                        input logic [7:0]  cfg);
    logic [7:0] r;
    case (p)
      2'd0:    r = shd[15:8];
      2'd1:    r = shd[7:0];
      2'd2:    r = cfg;
      default: r = DEV_ID;
    endcase
    return r;
  endfunction

  // ---- stage: pin synchronisers + edge history ----
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  // SCL must be high in both the current and previous sample so an SDA
  // change that races an SCL edge is never mistaken for START/STOP.
  assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

  // ---- stage: protocol state ----
  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [6:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [15:0] shadow_q, shadow_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        stb_q, stb_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;

  logic [7:0]  rx_byte;
  logic        last_bit;

  // Byte as it stands including the bit being sampled on this SCL rise.
  assign rx_byte  = {rx_sr_q, sda_s2_q};
  assign last_bit = (bitcnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      ptr_q    <= 2'd0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      cfg_q    <= CFG_RESET;
      stb_q    <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      ack_q    <= ack_d;
      cfg_q    <= cfg_d;
      stb_q    <= stb_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_sr_q  <= rx_sr_d;
    tx_sr_q  <= tx_sr_d;
    shadow_q <= shadow_d;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_sr_d  = rx_sr_q;
    tx_sr_d  = tx_sr_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    stb_d    = 1'b0;
    oe_d     = oe_q;
    busy_d   = busy_q;

    if (start_ev) begin
      // Also serves as repeated START from any point in a transfer.
      state_d  = S_ADDR;
      bitcnt_d = 3'd0;
      ack_d    = 1'b0;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_ev) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end

        S_ADDR: begin
          if (scl_rise) begin
            rx_sr_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                rw_d    = rx_byte[0];
                ack_d   = 1'b0;
                state_d = S_ADDR_ACK;
                if (rx_byte[0]) shadow_d = temp_in;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_PTR: begin
          if (scl_rise) begin
            rx_sr_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              ptr_d   = rx_byte[1:0];
              ack_d   = 1'b0;
              state_d = S_PTR_ACK;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            rx_sr_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              // Read-only targets still ACK and advance the pointer.
              if (ptr_q == 2'd2) begin
                cfg_d = rx_byte;
                stb_d = 1'b1;
              end
              ptr_d   = ptr_q + 2'd1;
              ack_d   = 1'b0;
              state_d = S_WDATA_ACK;
            end
          end
        end

        // First SCL fall after the 8th bit: drive ACK. Second fall: release
        // (or present the first read bit) and move on.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d    = 1'b0;
              oe_d     = 1'b0;
              bitcnt_d = 3'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                tx_sr_d = reg_rd(ptr_q, shadow_q, cfg_q);
                oe_d    = ~tx_sr_d[7];
                state_d = S_RDATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              ack_d   = 1'b0;
              state_d = S_RACK;
            end
          end else if (scl_fall) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            oe_d    = ~tx_sr_q[6];
          end
        end

        // ack_q=0: releasing after bit 8, then sampling the master's bit.
        // ack_q=1: master ACKed, present next byte on the 9th fall.
        S_RACK: begin
          if (scl_fall && !ack_q) begin
            oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = S_IDLE;
              oe_d    = 1'b0;
            end else begin
              ack_d = 1'b1;
              ptr_d = ptr_q + 2'd1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d    = 1'b0;
            bitcnt_d = 3'd0;
            tx_sr_d  = reg_rd(ptr_q, shadow_q, cfg_q);
            oe_d     = ~tx_sr_d[7];
            state_d  = S_RDATA;
          end
        end

        default: begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe     = oe_q;
  assign cfg_out    = cfg_q;
  assign cfg_wr_stb = stb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_sensor_slave.sv
module tb_i2c_sensor_slave;

  localparam int Q = 4;  // clk cycles per SCL quarter period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] temp_in = 16'h0000;
  logic        sda_oe;
  logic [7:0]  cfg_out;
  logic        cfg_wr_stb;
  logic        busy;
  wire         sda_line = m_sda & ~sda_oe;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int stb_cnt = 0;
  int stb_delay = 0;
  int oe_cnt = 0;

  i2c_sensor_slave dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .temp_in   (temp_in),
    .cfg_out   (cfg_out),
    .cfg_wr_stb(cfg_wr_stb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cfg_wr_stb) begin
      stb_cnt   <= stb_cnt + 1;
      stb_delay <= cyc - rise_cyc;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic send_bit(input logic b, output logic rd);
    repeat (Q) @(negedge clk);
    m_sda = b;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    rise_cyc = cyc;
    repeat (Q) @(negedge clk);
    rd = sda_line;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    repeat (Q) @(negedge clk);
    m_sda = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    m_sda = 1'b0;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    repeat (Q) @(negedge clk);
    m_sda = 1'b0;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    m_sda = 1'b1;
    repeat (2 * Q) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(~mack, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (cfg_out !== 8'h00) begin errors++; $display("FAIL reset_cfg_out: got %h expected 00", cfg_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_wr_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", cfg_wr_stb); end
  endtask

  task automatic test_cfg_write();
    logic a0, a1, a2;
    int   s0;
    s0 = stb_cnt;
    bus_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfgw_busy_start: got %b expected 1", busy); end
    write_byte(8'h90, a0);
    write_byte(8'h02, a1);
    write_byte(8'h3C, a2);
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL cfgw_ack_addr: got %b expected 1", a0); end
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL cfgw_ack_ptr: got %b expected 1", a1); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL cfgw_ack_data: got %b expected 1", a2); end
    checks++; if (cfg_out !== 8'h3C) begin errors++; $display("FAIL cfgw_cfg_out: got %h expected 3c", cfg_out); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL cfgw_stb_width: got %0d expected 1", stb_cnt - s0); end
    checks++; if (stb_delay !== 3) begin errors++; $display("FAIL cfgw_stb_delay: got %0d expected 3", stb_delay); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfgw_busy_before_stop: got %b expected 1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfgw_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_temp_read();
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    temp_in = 16'h1A2B;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h00, a1);
    bus_start();
    write_byte(8'h91, a2);
    read_byte(1'b1, d0);
    temp_in = 16'hFFFF;
    read_byte(1'b0, d1);
    bus_stop();
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL temp_ack_addr_w: got %b expected 1", a0); end
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL temp_ack_ptr: got %b expected 1", a1); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL temp_ack_addr_r: got %b expected 1", a2); end
    checks++; if (d0 !== 8'h1A) begin errors++; $display("FAIL temp_msb: got %h expected 1a", d0); end
    checks++; if (d1 !== 8'h2B) begin errors++; $display("FAIL temp_lsb_shadow: got %h expected 2b", d1); end
  endtask

  task automatic test_wrap_id();
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    temp_in = 16'h1A2B;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h03, a1);
    bus_start();
    write_byte(8'h91, a2);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    bus_stop();
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL wrap_ack_addr_r: got %b expected 1", a2); end
    checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL wrap_dev_id: got %h expected a5", d0); end
    checks++; if (d1 !== 8'h1A) begin errors++; $display("FAIL wrap_to_reg0: got %h expected 1a", d1); end
  endtask

  task automatic test_cfg_readback();
    logic       a0, a1, a2;
    logic [7:0] d0;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h02, a1);
    bus_start();
    write_byte(8'h91, a2);
    read_byte(1'b0, d0);
    bus_stop();
    checks++; if (d0 !== 8'h3C) begin errors++; $display("FAIL cfg_readback: got %h expected 3c", d0); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int   o0;
    o0 = oe_cnt;
    bus_start();
    write_byte(8'h92, a0);
    write_byte(8'h00, a1);
    bus_stop();
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL mis_ack_addr: got %b expected 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mis_ack_byte2: got %b expected 0", a1); end
    checks++; if (cfg_out !== 8'h3C) begin errors++; $display("FAIL mis_cfg_out: got %h expected 3c", cfg_out); end
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mis_sda_oe_cycles: got %0d expected 0", oe_cnt - o0); end
  endtask

  task automatic test_abort();
    logic a0, a1, r;
    int   s0;
    logic [7:0] b;
    s0 = stb_cnt;
    b = 8'h55;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h02, a1);
    for (int i = 7; i >= 4; i--) send_bit(b[i], r);
    bus_stop();
    checks++; if (cfg_out !== 8'h3C) begin errors++; $display("FAIL abort_cfg_out: got %h expected 3c", cfg_out); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL abort_stb: got %0d expected 0", stb_cnt - s0); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL abort_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rst_mid_read();
    logic a0, a1, a2, r;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h03, a1);
    bus_start();
    write_byte(8'h91, a2);
    send_bit(1'b1, r);  // bit 7 of A5 (1); bit 6 (0) follows with sda_oe=1
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL rstrd_bit7: got %b expected 1", r); end
    repeat (Q) @(negedge clk);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstrd_oe_before: got %b expected 1", sda_oe); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstrd_oe_after: got %b expected 0", sda_oe); end
    rst = 1'b0;
    m_sda = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (2 * Q) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrd_busy: got %b expected 0", busy); end
    checks++; if (cfg_out !== 8'h00) begin errors++; $display("FAIL rstrd_cfg_out: got %h expected 00", cfg_out); end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_temp_read();
    test_wrap_id();
    test_cfg_readback();
    test_mismatch();
    test_abort();
    test_rst_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
